sat_counter: RTL and testbench

SAT_COUNTER -- requirements
Module: sat_counter

---
 rtl/sat_counter_pkg.sv | 8 +
 rtl/sat_step.sv | 65 ++++++
 rtl/sat_counter.sv | 94 +++++++++
 tb/tb_sat_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sat_counter_pkg.sv
// Shared constants for the saturating/wrapping counter: mode encodings and default widths.
package sat_counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STEP_W = 4;
endpackage

// File: rtl/sat_step.sv
// Combinational next-value for one inc/dec: wraps modulo 2^WIDTH or clamps to [min, max].
// Purely combinational, no state; hit_o marks a wrap or clamp event.
module sat_step
    import sat_counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W
) (
    input  logic [WIDTH-1:0]  cur_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              up_i,
    input  logic              mode_i,
    input  logic [WIDTH-1:0]  min_i,
    input  logic [WIDTH-1:0]  max_i,
    output logic [WIDTH-1:0]  nxt_o,
    output logic              hit_o
);
    logic [WIDTH:0] cur_w;
    logic [WIDTH:0] step_w;
    logic [WIDTH:0] min_w;
    logic [WIDTH:0] max_w;
    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;
    logic [WIDTH:0] floor_w;

    assign cur_w   = {1'b0, cur_i};
    assign step_w  = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
    assign min_w   = {1'b0, min_i};
    assign max_w   = {1'b0, max_i};
    assign sum_w   = cur_w + step_w;
    assign diff_w  = cur_w - step_w;
    assign floor_w = min_w + step_w;

    always_comb begin
        nxt_o = cur_i;
        hit_o = 1'b0;
        if (step_w != '0) begin
            if (mode_i == MODE_WRAP) begin
                // Bit WIDTH of the wide result is the carry (inc) or borrow (dec).
                nxt_o = up_i ? sum_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
                hit_o = up_i ? sum_w[WIDTH]     : diff_w[WIDTH];
            end else if (cur_i < min_i) begin
                nxt_o = min_i;
                hit_o = 1'b1;
            end else if (cur_i > max_i) begin
                nxt_o = max_i;
                hit_o = 1'b1;
            end else if (up_i) begin
                if (sum_w > max_w) begin
                    nxt_o = max_i;
                    hit_o = 1'b1;
                end else begin
                    nxt_o = sum_w[WIDTH-1:0];
                end
            end else begin
                if (cur_w < floor_w) begin
                    nxt_o = min_i;
                    hit_o = 1'b1;
                end else begin
                    nxt_o = diff_w[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/sat_counter.sv
// Up/down counter with wrap or saturate mode, load, sticky overflow and one-cycle sat_hit pulse.
// One-cycle latency from command to register; no backpressure, a command is taken every cycle.
module sat_counter
    import sat_counter_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               STEP_W    = DEFAULT_STEP_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              increase,
    input  logic              decrease,
    input  logic [STEP_W-1:0] step,
    input  logic              mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              clear_flags,
    output logic [WIDTH-1:0]  register,
    output logic              at_max,
    output logic              at_min,
    output logic              sat_hit,
    output logic              overflow,
    output logic              cfg_err
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             sat_hit_q, sat_hit_d;
    logic             overflow_q;
    logic [WIDTH-1:0] step_nxt;
    logic             step_hit;
    logic             frozen;

    sat_step #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_step (
        .cur_i  (count_q),
        .step_i (step),
        .up_i   (increase),
        .mode_i (mode),
        .min_i  (min_val),
        .max_i  (max_val),
        .nxt_o  (step_nxt),
        .hit_o  (step_hit)
    );

    assign cfg_err = (min_val > max_val);
    // An inverted window makes clamping meaningless, so SAT mode freezes the count.
    assign frozen  = (mode == MODE_SAT) && cfg_err;

    always_comb begin
        count_d   = count_q;
        sat_hit_d = 1'b0;
        if (load) begin
            if (mode == MODE_WRAP) begin
                count_d = load_value;
            end else if (!frozen) begin
                if (load_value < min_val) begin
                    count_d   = min_val;
                    sat_hit_d = 1'b1;
                end else if (load_value > max_val) begin
                    count_d   = max_val;
                    sat_hit_d = 1'b1;
                end else begin
                    count_d = load_value;
                end
            end
        end else if (en && (increase || decrease) && !frozen) begin
            count_d   = step_nxt;
            sat_hit_d = step_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= RESET_VAL;
            sat_hit_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            sat_hit_q  <= sat_hit_d;
            overflow_q <= sat_hit_d || (overflow_q && !clear_flags);
        end
    end

    assign register = count_q;
    assign sat_hit  = sat_hit_q;
    assign overflow = overflow_q;
    assign at_max   = (count_q == max_val);
    assign at_min   = (count_q == min_val);
endmodule

// File: tb/tb_sat_counter.sv
// Directed test of sat_counter at WIDTH=8, STEP_W=4 with hand-computed expectations.
module tb_sat_counter;
    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst, en, increase, decrease, mode, load, clear_flags;
    logic [SW-1:0] step;
    logic [W-1:0]  load_value, min_val, max_val;
    logic [W-1:0]  register;
    logic          at_max, at_min, sat_hit, overflow, cfg_err;

    int tests  = 0;
    int failed = 0;

    sat_counter #(.WIDTH(W), .STEP_W(SW), .RESET_VAL(8'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .increase    (increase),
        .decrease    (decrease),
        .step        (step),
        .mode        (mode),
        .load        (load),
        .load_value  (load_value),
        .min_val     (min_val),
        .max_val     (max_val),
        .clear_flags (clear_flags),
        .register    (register),
        .at_max      (at_max),
        .at_min      (at_min),
        .sat_hit     (sat_hit),
        .overflow    (overflow),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_value = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_cmd(input logic inc, input logic dec, input logic [SW-1:0] s);
        en = 1'b1; increase = inc; decrease = dec; step = s;
        tick();
        en = 1'b0; increase = 1'b0; decrease = 1'b0;
    endtask

    task automatic do_clear();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; increase = 1'b0; decrease = 1'b0; step = '0;
        mode = 1'b0; load = 1'b0; load_value = '0; min_val = '0; max_val = '0;
        clear_flags = 1'b0;
        tick();
        chk("reset_reg", register, 0);
        chk("reset_sat_hit", sat_hit, 0);
        chk("reset_overflow", overflow, 0);

        rst = 1'b0;
        do_cmd(1, 0, 1); do_cmd(1, 0, 1); do_cmd(1, 0, 1);
        chk("inc_x3", register, 3);

        // WRAP carry
        do_load(8'd254);
        chk("wrap_load_254", register, 254);
        do_cmd(1, 0, 3);
        chk("wrap_inc_reg", register, 1);
        chk("wrap_inc_hit", sat_hit, 1);
        chk("wrap_inc_ovf", overflow, 1);
        tick();
        chk("wrap_hit_pulse_gone", sat_hit, 0);
        chk("wrap_ovf_sticky", overflow, 1);
        do_clear();
        chk("wrap_ovf_cleared", overflow, 0);

        // WRAP borrow
        do_cmd(0, 1, 2);
        chk("wrap_dec_reg", register, 255);
        chk("wrap_dec_hit", sat_hit, 1);
        do_clear();

        // set and clear in same cycle: set wins
        do_load(8'd255);
        clear_flags = 1'b1;
        do_cmd(1, 0, 1);
        clear_flags = 1'b0;
        chk("set_beats_clear_reg", register, 0);
        chk("set_beats_clear_ovf", overflow, 1);
        do_clear();

        // SAT clamps
        mode = 1'b1; min_val = 8'd10; max_val = 8'd200;
        do_load(8'd100);
        do_cmd(1, 0, 5);
        chk("sat_inc_plain", register, 105);
        chk("sat_inc_plain_hit", sat_hit, 0);
        do_load(8'd198);
        do_cmd(1, 0, 5);
        chk("sat_inc_clamp_reg", register, 200);
        chk("sat_inc_at_max", at_max, 1);
        chk("sat_inc_hit", sat_hit, 1);
        do_load(8'd12);
        do_cmd(0, 1, 5);
        chk("sat_dec_clamp_reg", register, 10);
        chk("sat_dec_at_min", at_min, 1);
        chk("sat_dec_hit", sat_hit, 1);
        do_clear();

        // SAT load clamp, WRAP load passthrough
        do_load(8'd250);
        chk("sat_load_clamp", register, 200);
        chk("sat_load_ovf", overflow, 1);
        do_clear();
        mode = 1'b0;
        do_load(8'd250);
        chk("wrap_load_250", register, 250);
        chk("wrap_load_no_hit", sat_hit, 0);
        chk("wrap_load_no_ovf", overflow, 0);

        // out-of-window start in SAT clamps to violated bound
        mode = 1'b1;
        do_cmd(1, 0, 1);
        chk("sat_above_clamp", register, 200);
        chk("sat_above_hit", sat_hit, 1);
        mode = 1'b0;
        do_load(8'd5);
        mode = 1'b1;
        do_cmd(1, 0, 1);
        chk("sat_below_clamp", register, 10);
        do_clear();

        // both directions, zero step, enable low
        mode = 1'b0;
        do_load(8'd50);
        do_cmd(1, 1, 2);
        chk("both_inc_only", register, 52);
        do_cmd(1, 0, 0);
        chk("step0_hold", register, 52);
        chk("step0_no_hit", sat_hit, 0);
        chk("step0_no_ovf", overflow, 0);
        increase = 1'b1; step = 4'd2;
        tick();
        increase = 1'b0;
        chk("en0_hold", register, 52);

        // inverted window in SAT freezes count
        mode = 1'b1; min_val = 8'd100; max_val = 8'd50;
        #1;
        chk("cfg_err_high", cfg_err, 1);
        do_cmd(1, 0, 3);
        chk("cfg_err_inc_ignored", register, 52);
        chk("cfg_err_no_hit", sat_hit, 0);
        do_load(8'd77);
        chk("cfg_err_load_ignored", register, 52);
        mode = 1'b0;
        do_cmd(1, 0, 3);
        chk("cfg_err_wrap_counts", register, 55);

        // reset mid-count discards the command and clears flags
        do_load(8'd255);
        do_cmd(1, 0, 1);
        chk("pre_rst_ovf", overflow, 1);
        en = 1'b1; increase = 1'b1; step = 4'd4; rst = 1'b1; load = 1'b1; load_value = 8'd9;
        tick();
        chk("rst_reg", register, 0);
        chk("rst_hit", sat_hit, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0; load = 1'b0;
        tick();
        en = 1'b0; increase = 1'b0;
        chk("resume_after_rst", register, 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
